// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ mem_handle requesters.
// One transaction in flight at a time; reports protocol misuse and memory timeouts.
module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [NUM_REQ-1:0]    req_avail,
  input  logic [NUM_REQ-1:0]    req_r_en,
  input  logic [NUM_REQ-1:0]    req_w_en,
  input  logic [NUM_REQ*AW-1:0] req_ptr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [DW-1:0]         req_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ack,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  err_proto,
  output logic                  err_timeout,
  output logic                  busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_last;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  w_valid;
  logic                w_any;
  logic                w_bad;
  logic                w_tmo;
  logic [GW-1:0]       w_pick;

  // Closest valid index above 'last', wrapping; scanning downward lets the nearest one win.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    int            idx;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (v[GW'(idx)]) pick = GW'(idx);
    end
    return pick;
  endfunction

  assign w_valid = req_avail & (req_r_en ^ req_w_en);
  assign w_any   = |w_valid;
  assign w_bad   = |(req_avail & ~(req_r_en ^ req_w_en));
  assign w_tmo   = (r_cnt == CNT_LAST);
  assign w_pick  = rr_pick(w_valid, r_last);
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   if (mem_ack || w_tmo) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_grant     <= '0;
      r_last      <= GW'(NUM_REQ - 1);
      r_cnt       <= '0;
      req_done    <= '0;
      req_rdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      err_proto   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (w_bad) err_proto <= 1'b1;
      case (r_state)
        IDLE: begin
          // Address/data are captured once here so later requester changes cannot leak in.
          if (w_any) begin
            r_grant   <= w_pick;
            r_last    <= w_pick;
            mem_addr  <= req_ptr[w_pick*AW +: AW];
            mem_wdata <= req_wdata[w_pick*DW +: DW];
            mem_we    <= req_w_en[w_pick];
            mem_req   <= 1'b1;
            r_cnt     <= '0;
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack || w_tmo) begin
            mem_req  <= 1'b0;
            req_done <= NUM_REQ'(1) << r_grant;
          end
          if (mem_ack) begin
            if (!mem_we) req_rdata <= mem_rdata;
          end else if (w_tmo) begin
            err_timeout <= 1'b1;
            req_rdata   <= '0;
          end
        end
        RESP: begin
          req_done <= '0;
          r_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter (4 requesters, TIMEOUT=8).
module tb_mem_port_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic [NR-1:0]    req_avail = '0;
  logic [NR-1:0]    req_r_en = '0;
  logic [NR-1:0]    req_w_en = '0;
  logic [NR*AW-1:0] req_ptr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_done;
  logic [DW-1:0]    req_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_ack = 1'b0;
  logic [DW-1:0]    mem_rdata = '0;
  logic             err_proto;
  logic             err_timeout;
  logic             busy;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
    .req_ptr(req_ptr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_proto(err_proto), .err_timeout(err_timeout), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] p, input logic [DW-1:0] d);
    req_avail[i] = 1'b1;
    req_r_en[i]  = !wr;
    req_w_en[i]  = wr;
    req_ptr[i*AW +: AW]   = p;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic drop_req(input int i);
    req_avail[i] = 1'b0;
    req_r_en[i]  = 1'b0;
    req_w_en[i]  = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    mem_ack = 1'b0;
    tick();
    tick();
    vecs++;
    if ({mem_req, mem_we, busy, err_proto, err_timeout, req_done, mem_addr, mem_wdata, req_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b we=%b busy=%b ep=%b et=%b done=%b addr=%h wd=%h rd=%h, all required 0",
               mem_req, mem_we, busy, err_proto, err_timeout, req_done, mem_addr, mem_wdata, req_rdata);
    end
    rst_l = 1'b1;
    tick();
    vecs++;
    if ({busy, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: busy/mem_req=%b required 00", {busy, mem_req});
    end
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 32'h10, 32'h0);
    tick();
    vecs++;
    if ({mem_req, mem_we, busy, req_done, mem_addr} !== {3'b101, 4'b0000, 32'h10}) begin
      miscompares++;
      $display("FAIL rd_issue: req=%b we=%b busy=%b done=%b addr=%h required 1 0 1 0000 00000010",
               mem_req, mem_we, busy, req_done, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    vecs++;
    if ({mem_req, req_done, req_rdata} !== {1'b0, 4'b0001, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL rd_done: req=%b done=%b rdata=%h required 0 0001 deadbeef", mem_req, req_done, req_rdata);
    end
    mem_ack = 1'b0;
    drop_req(0);
    tick();
    vecs++;
    if ({busy, mem_req, req_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL rd_after: busy=%b req=%b done=%b required 0 0 0000", busy, mem_req, req_done);
    end
  endtask

  task automatic test_write_wait();
    set_req(2, 1'b1, 32'h20, 32'h3F800000);
    tick();
    for (int c = 1; c <= 4; c++) begin
      vecs++;
      if ({mem_req, mem_we, req_done, mem_addr, mem_wdata} !== {2'b11, 4'b0000, 32'h20, 32'h3F800000}) begin
        miscompares++;
        $display("FAIL wr_hold_c%0d: req=%b we=%b done=%b addr=%h wd=%h required 1 1 0000 00000020 3f800000",
                 c, mem_req, mem_we, req_done, mem_addr, mem_wdata);
      end
      if (c == 1) begin
        req_ptr[2*AW +: AW]   = 32'hFFFF_0000;
        req_wdata[2*DW +: DW] = 32'h1234_5678;
      end
      if (c == 4) begin
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
      end
      tick();
    end
    vecs++;
    if ({mem_req, req_done, req_rdata, err_proto, err_timeout} !== {1'b0, 4'b0100, 32'hDEADBEEF, 2'b00}) begin
      miscompares++;
      $display("FAIL wr_done: req=%b done=%b rdata=%h ep=%b et=%b required 0 0100 deadbeef 0 0",
               mem_req, req_done, req_rdata, err_proto, err_timeout);
    end
    mem_ack = 1'b0;
    drop_req(2);
    tick();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_done;
    int g;
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h1000 + i, 32'h0);
    mem_ack = 1'b1;
    for (int c = 0; c < 18; c++) begin
      g = (c / 3) % NR;
      exp_done = (c % 3 == 2) ? NR'(1 << g) : '0;
      vecs++;
      if (req_done !== exp_done) begin
        miscompares++;
        $display("FAIL rr_done_c%0d: done=%b required %b", c, req_done, exp_done);
      end
      if (c % 3 == 1) begin
        vecs++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h1000 + g}) begin
          miscompares++;
          $display("FAIL rr_addr_c%0d: req=%b addr=%h required 1 %h", c, mem_req, mem_addr, 32'h1000 + g);
        end
      end
      if (c % 3 == 2) begin
        vecs++;
        if (req_rdata !== 32'h100 + c - 1) begin
          miscompares++;
          $display("FAIL rr_rdata_c%0d: rdata=%h required %h", c, req_rdata, 32'h100 + c - 1);
        end
      end
      mem_rdata = 32'h100 + c;
      tick();
    end
    for (int i = 0; i < NR; i++) drop_req(i);
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_proto_err();
    req_avail[1] = 1'b1;
    req_r_en[1]  = 1'b1;
    req_w_en[1]  = 1'b1;
    req_ptr[1*AW +: AW] = 32'hEEEE;
    set_req(3, 1'b0, 32'h30, 32'h0);
    tick();
    vecs++;
    if ({mem_req, mem_addr, err_proto} !== {1'b1, 32'h30, 1'b1}) begin
      miscompares++;
      $display("FAIL pe_issue: req=%b addr=%h ep=%b required 1 00000030 1", mem_req, mem_addr, err_proto);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h33;
    tick();
    vecs++;
    if ({req_done, req_rdata} !== {4'b1000, 32'h33}) begin
      miscompares++;
      $display("FAIL pe_done: done=%b rdata=%h required 1000 00000033", req_done, req_rdata);
    end
    mem_ack = 1'b0;
    drop_req(3);
    tick();
    tick();
    vecs++;
    if ({busy, mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL pe_no_grant: busy=%b req=%b required 0 0", busy, mem_req);
    end
    drop_req(1);
    tick();
    vecs++;
    if (err_proto !== 1'b1) begin
      miscompares++;
      $display("FAIL pe_sticky: err_proto=%b required 1", err_proto);
    end
  endtask

  task automatic test_timeout();
    // Ack arriving on the final allowed cycle must complete normally.
    set_req(0, 1'b0, 32'h40, 32'h0);
    mem_rdata = 32'h77;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      vecs++;
      if ({mem_req, req_done} !== 5'b10000) begin
        miscompares++;
        $display("FAIL ackwin_c%0d: req=%b done=%b required 1 0000", c, mem_req, req_done);
      end
      if (c == TMO) mem_ack = 1'b1;
      tick();
    end
    vecs++;
    if ({mem_req, req_done, req_rdata, err_timeout} !== {1'b0, 4'b0001, 32'h77, 1'b0}) begin
      miscompares++;
      $display("FAIL ackwin_done: req=%b done=%b rdata=%h et=%b required 0 0001 00000077 0",
               mem_req, req_done, req_rdata, err_timeout);
    end
    mem_ack = 1'b0;
    drop_req(0);
    tick();
    set_req(0, 1'b0, 32'h44, 32'h0);
    mem_rdata = 32'hBAD;
    tick();
    for (int c = 1; c <= TMO; c++) begin
      vecs++;
      if ({mem_req, req_done} !== 5'b10000) begin
        miscompares++;
        $display("FAIL tmo_wait_c%0d: req=%b done=%b required 1 0000", c, mem_req, req_done);
      end
      tick();
    end
    vecs++;
    if ({mem_req, req_done, req_rdata, err_timeout} !== {1'b0, 4'b0001, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL tmo_done: req=%b done=%b rdata=%h et=%b required 0 0001 00000000 1",
               mem_req, req_done, req_rdata, err_timeout);
    end
    drop_req(0);
    tick();
    set_req(1, 1'b0, 32'h50, 32'h0);
    tick();
    vecs++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h50}) begin
      miscompares++;
      $display("FAIL tmo_next_issue: req=%b addr=%h required 1 00000050", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h55;
    tick();
    vecs++;
    if ({req_done, req_rdata, err_timeout} !== {4'b0010, 32'h55, 1'b1}) begin
      miscompares++;
      $display("FAIL tmo_next_done: done=%b rdata=%h et=%b required 0010 00000055 1", req_done, req_rdata, err_timeout);
    end
    mem_ack = 1'b0;
    drop_req(1);
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, 1'b0, 32'h60, 32'h0);
    tick();
    tick();
    vecs++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h60}) begin
      miscompares++;
      $display("FAIL rstmid_wait: req=%b addr=%h required 1 00000060", mem_req, mem_addr);
    end
    rst_l = 1'b0;
    set_req(0, 1'b0, 32'h70, 32'h0);
    #1;
    vecs++;
    if ({mem_req, busy, err_proto, err_timeout} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_async: req=%b busy=%b ep=%b et=%b required 0 0 0 0", mem_req, busy, err_proto, err_timeout);
    end
    tick();
    vecs++;
    if (req_done !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_nodone: done=%b required 0000", req_done);
    end
    rst_l = 1'b1;
    tick();
    vecs++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h70}) begin
      miscompares++;
      $display("FAIL rstmid_first: req=%b addr=%h required 1 00000070", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h99;
    tick();
    vecs++;
    if ({req_done, req_rdata} !== {4'b0001, 32'h99}) begin
      miscompares++;
      $display("FAIL rstmid_done0: done=%b rdata=%h required 0001 00000099", req_done, req_rdata);
    end
    mem_ack = 1'b0;
    drop_req(0);
    tick();
    tick();
    vecs++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h60}) begin
      miscompares++;
      $display("FAIL rstmid_second: req=%b addr=%h required 1 00000060", mem_req, mem_addr);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hAA;
    tick();
    vecs++;
    if ({req_done, req_rdata} !== {4'b0100, 32'hAA}) begin
      miscompares++;
      $display("FAIL rstmid_done2: done=%b rdata=%h required 0100 000000aa", req_done, req_rdata);
    end
    mem_ack = 1'b0;
    drop_req(2);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_proto_err();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
